tlc_serial_rx: RTL and testbench

// - Receiving end of the LED-driver serial link (SCLK/SDO/LAT): captures the bitstream shifted out by the driver FSM.
// - Deserialises DAISY_LEN chained frames of FRAME_BITS bits each. On each LAT rising edge it emits them one by one over valid/ready.
// - Uses: loopback checking of the LED controller, and capture of driver SOUT readback.

---
 rtl/tlc_serial_rx.sv | 133 +++++++++++++
 tb/tb_tlc_serial_rx.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_serial_rx.sv
// tlc_serial_rx: receiving end of the LED-driver serial link (SCLK/SDO/LAT).
// Shifts in DAISY_LEN chained frames of FRAME_BITS bits, MSB of the stream
// first. On a LAT rising edge with the right bit count, the frames are handed
// out one at a time over valid/ready. idx 0 is the frame received last.
// Optional build macro: RX_SYNC_EN adds 2-FF synchronisers on SCLK_IN,
// LAT_IN and SDI so that the link may be asynchronous to CLK_10M.
`timescale 1ns/1ps
module tlc_serial_rx #(
  parameter int FRAME_BITS = 769,
  parameter int DAISY_LEN  = 2,
  localparam int N     = FRAME_BITS * DAISY_LEN,
  localparam int IDX_W = (DAISY_LEN > 1) ? $clog2(DAISY_LEN) : 1,
  localparam int CNT_W = $clog2(N + 2)
) (
  input  logic                  CLK_10M,
  input  logic                  RESET,
  input  logic                  SCLK_IN,
  input  logic                  SDI,
  input  logic                  LAT_IN,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [IDX_W-1:0]      frame_idx,
  output logic                  frame_is_ctrl,
  output logic                  len_err,
  output logic                  overrun,
  output logic [CNT_W-1:0]      bit_cnt
);

  typedef enum logic {RECV = 1'b0, EMIT = 1'b1} state_t;

  state_t           state;
  logic [N-1:0]     sr;
  logic             sclk_s, lat_s, sdi_s;
  logic             sclk_prev, lat_prev;
  logic             sclk_rise, lat_rise;
  logic [CNT_W-1:0] cnt_inc, cnt_after;

`ifdef RX_SYNC_EN
  logic [2:0] sync_q1, sync_q2;

  // Two-stage synchroniser for the asynchronous link inputs.
  always_ff @(posedge CLK_10M) begin
    if (RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {SCLK_IN, LAT_IN, SDI};
      sync_q2 <= sync_q1;
    end
  end

  assign {sclk_s, lat_s, sdi_s} = sync_q2;
`else
  assign sclk_s = SCLK_IN;
  assign lat_s  = LAT_IN;
  assign sdi_s  = SDI;
`endif

  // Delayed copies for edge detection; reset high so a line already high is not an edge.
  always_ff @(posedge CLK_10M) begin
    if (RESET) begin
      sclk_prev <= 1'b1;
      lat_prev  <= 1'b1;
    end else begin
      sclk_prev <= sclk_s;
      lat_prev  <= lat_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign lat_rise  = lat_s & ~lat_prev;

  // Saturating bit count; a coincident SCLK edge is counted before the LAT check.
  assign cnt_inc   = (bit_cnt == CNT_W'(N + 1)) ? bit_cnt : bit_cnt + CNT_W'(1);
  assign cnt_after = sclk_rise ? cnt_inc : bit_cnt;

  // The lowest frame of the shift register is always the one on offer.
  assign frame_data    = sr[FRAME_BITS-1:0];
  assign frame_is_ctrl = sr[FRAME_BITS-1];

  // Receive/emit state machine with all state and flags registered.
  always_ff @(posedge CLK_10M) begin
    if (RESET) begin
      state       <= RECV;
      sr          <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_idx   <= '0;
      len_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch sees
      // the pre-edge values; the default below makes len_err a 1-cycle pulse.
      len_err <= 1'b0;
      case (state)
        RECV: begin
          if (sclk_rise) sr <= {sr[N-2:0], sdi_s};
          if (lat_rise) begin
            if (cnt_after == CNT_W'(N)) begin
              state       <= EMIT;
              frame_valid <= 1'b1;
              frame_idx   <= '0;
              bit_cnt     <= cnt_after;
            end else begin
              len_err <= 1'b1;
              bit_cnt <= '0;
            end
          end else if (sclk_rise) begin
            bit_cnt <= cnt_inc;
          end
        end
        EMIT: begin
          if (sclk_rise) overrun <= 1'b1;
          if (lat_rise)  len_err <= 1'b1;
          if (frame_ready) begin
            sr <= sr >> FRAME_BITS;
            if (frame_idx == IDX_W'(DAISY_LEN - 1)) begin
              state       <= RECV;
              frame_valid <= 1'b0;
              frame_idx   <= '0;
              bit_cnt     <= '0;
            end else begin
              frame_idx <= frame_idx + IDX_W'(1);
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_serial_rx.sv
// Directed bench for tlc_serial_rx: control/grayscale loops, short stream,
// backpressure with overrun, SCLK/LAT coincidence and reset during emit.
`timescale 1ns/1ps
module tb_tlc_serial_rx;

  localparam int FB = 769;
  localparam int NB = 1538;

  logic          CLK_10M = 1'b0;
  logic          RESET = 1'b1;
  logic          SCLK_IN = 1'b0;
  logic          SDI = 1'b0;
  logic          LAT_IN = 1'b0;
  logic          frame_ready = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid;
  logic [0:0]    frame_idx;
  logic          frame_is_ctrl;
  logic          len_err;
  logic          overrun;
  logic [10:0]   bit_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int len_err_seen = 0;
  int valid_seen = 0;

  tlc_serial_rx dut (
    .CLK_10M      (CLK_10M),
    .RESET        (RESET),
    .SCLK_IN      (SCLK_IN),
    .SDI          (SDI),
    .LAT_IN       (LAT_IN),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_idx    (frame_idx),
    .frame_is_ctrl(frame_is_ctrl),
    .len_err      (len_err),
    .overrun      (overrun),
    .bit_cnt      (bit_cnt)
  );

  always #50 CLK_10M = ~CLK_10M;

  // Running counts of len_err pulses and valid cycles, sampled away from the active edge.
  always @(negedge CLK_10M) begin
    if (len_err === 1'b1) len_err_seen++;
    if (frame_valid === 1'b1) valid_seen++;
  end

  initial begin
    #6_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FB-1:0] make_frame(input logic [31:0] seed, input logic ctrl);
    logic [799:0]  rep;
    logic [FB-1:0] f;
    rep = {25{seed}};
    f = rep[FB-1:0];
    f[FB-1] = ctrl;
    if (ctrl) f[370:366] = 5'b11111;
    return f;
  endfunction

  function automatic logic [FB-1:0] make_gray_blue();
    logic [FB-1:0] f;
    f = '0;
    for (int k = 0; k < 48; k++)
      if (k % 3 == 2) f[k*16 +: 16] = 16'hFFFF;
    return f;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge CLK_10M);
    SDI = b;
    SCLK_IN = 1'b1;
    @(negedge CLK_10M);
    SCLK_IN = 1'b0;
  endtask

  task automatic send_frame(input logic [FB-1:0] f);
    for (int i = FB - 1; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic pulse_lat();
    @(negedge CLK_10M);
    LAT_IN = 1'b1;
    @(negedge CLK_10M);
    LAT_IN = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK_10M);
    end
  endtask

  // Waits for the first frame, then accepts both with ready held high.
  task automatic collect(output logic [FB-1:0] d0, output logic [FB-1:0] d1,
                         output logic c0, output logic c1,
                         output logic [0:0] i0, output logic [0:0] i1, output bit ok);
    d0 = 'x; d1 = 'x; c0 = 1'bx; c1 = 1'bx; i0 = 1'bx; i1 = 1'bx;
    wait_valid(ok);
    if (!ok) return;
    d0 = frame_data; c0 = frame_is_ctrl; i0 = frame_idx;
    frame_ready = 1'b1;
    @(negedge CLK_10M);
    d1 = frame_data; c1 = frame_is_ctrl; i1 = frame_idx;
    @(negedge CLK_10M);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK_10M);
    RESET = 1'b0;
    @(negedge CLK_10M);
    tests_run++;
    if ({frame_valid, len_err, overrun, frame_is_ctrl} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b expected 0000", {frame_valid, len_err, overrun, frame_is_ctrl});
    end
    tests_run++;
    if (bit_cnt !== 11'd0 || frame_idx !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_counts got bit_cnt=%0d idx=%0d expected 0/0", bit_cnt, frame_idx);
    end
    tests_run++;
    if (frame_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got %h expected 0", frame_data);
    end
  endtask

  task automatic test_ctrl_loop();
    logic [FB-1:0] f0, f1, d0, d1;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok;
    int le0;
    f1 = make_frame(32'hA5C3_0F17, 1'b1);
    f0 = make_frame(32'h1234_5678, 1'b1);
    le0 = len_err_seen;
    send_frame(f1);
    send_frame(f0);
    tests_run++;
    if (bit_cnt !== 11'(NB)) begin
      tests_failed++;
      $display("FAIL ctrl_bit_cnt got %0d expected %0d", bit_cnt, NB);
    end
    pulse_lat();
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL ctrl_valid_timeout got valid=0 expected 1");
    end
    tests_run++;
    if (i0 !== 1'b0 || i1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ctrl_idx got %b,%b expected 0,1", i0, i1);
    end
    tests_run++;
    if (c0 !== 1'b1 || c1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ctrl_is_ctrl got %b,%b expected 1,1", c0, c1);
    end
    tests_run++;
    if (d0 !== f0) begin
      tests_failed++;
      $display("FAIL ctrl_data0 got %h expected %h", d0, f0);
    end
    tests_run++;
    if (d1 !== f1) begin
      tests_failed++;
      $display("FAIL ctrl_data1 got %h expected %h", d1, f1);
    end
    tests_run++;
    if (frame_valid !== 1'b0 || len_err_seen != le0) begin
      tests_failed++;
      $display("FAIL ctrl_end got valid=%b len_err_pulses=%0d expected 0/0", frame_valid, len_err_seen - le0);
    end
  endtask

  task automatic test_gray_blue();
    logic [FB-1:0] f, d0, d1;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok;
    f = make_gray_blue();
    send_frame(f);
    send_frame(f);
    pulse_lat();
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok || c0 !== 1'b0 || c1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL gray_is_ctrl got ok=%0d %b,%b expected 1 0,0", ok, c0, c1);
    end
    tests_run++;
    if (d0[47:32] !== 16'hFFFF || d1[47:32] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL gray_blue0 got %h,%h expected ffff,ffff", d0[47:32], d1[47:32]);
    end
    tests_run++;
    if (d0 !== f || d1 !== f) begin
      tests_failed++;
      $display("FAIL gray_data got %h expected %h", d0, f);
    end
    tests_run++;
    if (bit_cnt !== 11'd0) begin
      tests_failed++;
      $display("FAIL gray_bit_cnt_after got %0d expected 0", bit_cnt);
    end
  endtask

  task automatic test_short_stream();
    logic [FB-1:0] f0, f1, d0, d1;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok;
    int le0, vs0;
    le0 = len_err_seen;
    vs0 = valid_seen;
    for (int i = 0; i < 1000; i++) send_bit(i[1] ^ i[0]);
    pulse_lat();
    repeat (4) @(negedge CLK_10M);
    tests_run++;
    if (len_err_seen - le0 != 1) begin
      tests_failed++;
      $display("FAIL short_len_err got %0d pulses expected 1", len_err_seen - le0);
    end
    tests_run++;
    if (valid_seen != vs0 || bit_cnt !== 11'd0) begin
      tests_failed++;
      $display("FAIL short_no_emit got valid_cycles=%0d bit_cnt=%0d expected 0/0", valid_seen - vs0, bit_cnt);
    end
    f1 = make_frame(32'h0F0F_3C3C, 1'b0);
    f0 = make_frame(32'hDEAD_BEEF, 1'b1);
    send_frame(f1);
    send_frame(f0);
    pulse_lat();
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok || d0 !== f0 || d1 !== f1) begin
      tests_failed++;
      $display("FAIL short_recovery got %h expected %h", d0, f0);
    end
  endtask

  task automatic test_backpressure();
    logic [FB-1:0] f0, f1, d0, d1, hold;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok, stable;
    f1 = make_frame(32'h8421_7BDE, 1'b1);
    f0 = make_frame(32'h5555_AAAA, 1'b0);
    send_frame(f1);
    send_frame(f0);
    pulse_lat();
    wait_valid(ok);
    tests_run++;
    if (!ok || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_start got ok=%0d overrun=%b expected 1/0", ok, overrun);
    end
    hold = frame_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SCLK_IN = (i == 8);
      SDI = 1'b1;
      @(negedge CLK_10M);
      if (frame_data !== hold || frame_idx !== 1'b0 || frame_valid !== 1'b1) stable = 1'b0;
    end
    SCLK_IN = 1'b0;
    tests_run++;
    if (!stable || hold !== f0) begin
      tests_failed++;
      $display("FAIL bp_stable got stable=%0d data %h expected %h", stable, hold, f0);
    end
    tests_run++;
    if (overrun !== 1'b1 || bit_cnt !== 11'(NB)) begin
      tests_failed++;
      $display("FAIL bp_overrun got overrun=%b bit_cnt=%0d expected 1/%0d", overrun, bit_cnt, NB);
    end
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok || d0 !== f0 || d1 !== f1) begin
      tests_failed++;
      $display("FAIL bp_data got %h expected %h", d1, f1);
    end
  endtask

  task automatic test_edge_coincidence();
    logic [FB-1:0] f0, f1, d0, d1;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok;
    int le0;
    f1 = make_frame(32'h3141_5926, 1'b0);
    f0 = make_frame(32'h2718_2818, 1'b1);
    f0[0] = 1'b1;
    le0 = len_err_seen;
    send_frame(f1);
    for (int i = FB - 1; i >= 1; i--) send_bit(f0[i]);
    @(negedge CLK_10M);
    SDI = f0[0];
    SCLK_IN = 1'b1;
    LAT_IN = 1'b1;
    @(negedge CLK_10M);
    SCLK_IN = 1'b0;
    LAT_IN = 1'b0;
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok || len_err_seen != le0) begin
      tests_failed++;
      $display("FAIL coinc_accept got ok=%0d len_err_pulses=%0d expected 1/0", ok, len_err_seen - le0);
    end
    tests_run++;
    if (d0[0] !== 1'b1 || d0 !== f0 || d1 !== f1) begin
      tests_failed++;
      $display("FAIL coinc_data got %h expected %h", d0, f0);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [FB-1:0] f0, f1, d0, d1;
    logic c0, c1;
    logic [0:0] i0, i1;
    bit ok;
    f1 = make_frame(32'hCAFE_F00D, 1'b1);
    f0 = make_frame(32'h0BAD_C0DE, 1'b1);
    send_frame(f1);
    send_frame(f0);
    pulse_lat();
    wait_valid(ok);
    frame_ready = 1'b1;
    @(negedge CLK_10M);
    frame_ready = 1'b0;
    tests_run++;
    if (!ok || frame_idx !== 1'b1 || frame_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_emit_pre got ok=%0d idx=%b valid=%b expected 1/1/1", ok, frame_idx, frame_valid);
    end
    RESET = 1'b1;
    @(negedge CLK_10M);
    tests_run++;
    if ({frame_valid, frame_idx, frame_is_ctrl, len_err, overrun} !== 5'b0 || bit_cnt !== 11'd0 || frame_data !== '0) begin
      tests_failed++;
      $display("FAIL rst_emit_clear got flags=%b bit_cnt=%0d expected 0/0",
               {frame_valid, frame_idx, frame_is_ctrl, len_err, overrun}, bit_cnt);
    end
    RESET = 1'b0;
    @(negedge CLK_10M);
    f1 = make_frame(32'h7777_1111, 1'b0);
    f0 = make_frame(32'h9999_EEEE, 1'b0);
    send_frame(f1);
    send_frame(f0);
    pulse_lat();
    collect(d0, d1, c0, c1, i0, i1, ok);
    tests_run++;
    if (!ok || d0 !== f0 || d1 !== f1 || i0 !== 1'b0 || i1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_emit_fresh got %h expected %h", d0, f0);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_loop();
    test_gray_blue();
    test_short_stream();
    test_backpressure();
    test_edge_coincidence();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
